// File: rtl/sensor_conditioner.sv
// Sensor front end: per-channel 2-flop synchronizer, debounce, and a request latch
// that holds each debounced press until the controller acknowledges it.
module sensor_conditioner #(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sensors_raw,
  input  logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] sensors_db,
  output logic [N_CH-1:0] req,
  output logic            req_any,
  output logic [2:0]      req_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  s1_q;
  logic [N_CH-1:0]  s2_q;
  logic [N_CH-1:0]  db_q;
  logic [N_CH-1:0]  db_d;
  logic [N_CH-1:0]  req_q;
  logic [N_CH-1:0]  req_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      req_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= sensors_raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      req_q <= req_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    db_d  = db_q;
    req_d = req_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A fresh debounced press outranks a same-edge ack so it is never lost.
      if (!db_q[i] && db_d[i]) begin
        req_d[i] = 1'b1;
      end else if (ack[i]) begin
        req_d[i] = 1'b0;
      end
    end
  end

  // Lowest-numbered pending request wins; scan downward so the last hit is lowest.
  always_comb begin
    req_idx = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_q[i]) req_idx = 3'(i);
    end
  end

  assign req_any    = |req_q;
  assign sensors_db = db_q;
  assign req        = req_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with a short debounce window (4 cycles).
module tb_sensor_conditioner;

  localparam int N_CH = 5;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] sensors_raw;
  logic [N_CH-1:0] ack;
  logic [N_CH-1:0] sensors_db;
  logic [N_CH-1:0] req;
  logic            req_any;
  logic [2:0]      req_idx;

  int checks;
  int failures;

  sensor_conditioner #(
    .N_CH(N_CH),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensors_raw(sensors_raw),
    .ack(ack),
    .sensors_db(sensors_db),
    .req(req),
    .req_any(req_any),
    .req_idx(req_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] db, input logic [4:0] rq,
                           input logic any, input logic [2:0] idx);
    check({tag, ".db"},  32'(sensors_db), 32'(db));
    check({tag, ".req"}, 32'(req),        32'(rq));
    check({tag, ".any"}, 32'(req_any),    32'(any));
    check({tag, ".idx"}, 32'(req_idx),    32'(idx));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    sensors_raw = '0;
    ack         = '0;
    tick(2);
    reset = 1'b0;
    check_all("reset", 5'b00000, 5'b00000, 1'b0, 3'd0);

    // Scenario 1: raw[2] rises before edge 0; level and request appear after edge 5.
    sensors_raw = 5'b00100;
    tick(5);
    check_all("s1_edge4", 5'b00000, 5'b00000, 1'b0, 3'd0);
    tick(1);
    check_all("s1_edge5", 5'b00100, 5'b00100, 1'b1, 3'd2);

    // Scenario 3: one-cycle ack clears req while the level stays high.
    ack = 5'b00100;
    tick(1);
    ack = '0;
    check_all("s3_ack", 5'b00100, 5'b00000, 1'b0, 3'd0);
    tick(3);
    check_all("s3_hold", 5'b00100, 5'b00000, 1'b0, 3'd0);
    sensors_raw = 5'b00000;
    tick(5);
    check_all("s3_rel_edge4", 5'b00100, 5'b00000, 1'b0, 3'd0);
    tick(1);
    check_all("s3_rel_edge5", 5'b00000, 5'b00000, 1'b0, 3'd0);
    sensors_raw = 5'b00100;
    tick(5);
    check_all("s3_repress_edge4", 5'b00000, 5'b00000, 1'b0, 3'd0);
    tick(1);
    check_all("s3_relatch", 5'b00100, 5'b00100, 1'b1, 3'd2);
    ack = 5'b00100;
    tick(1);
    ack = '0;
    sensors_raw = 5'b00000;
    tick(8);
    check_all("s3_clean", 5'b00000, 5'b00000, 1'b0, 3'd0);

    // Scenario 2: two 3-cycle pulses on raw[3] are both rejected.
    for (int p = 0; p < 2; p++) begin
      sensors_raw = 5'b01000;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check_all("s2_pulse_hi", 5'b00000, 5'b00000, 1'b0, 3'd0);
      end
      sensors_raw = 5'b00000;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        check_all("s2_pulse_lo", 5'b00000, 5'b00000, 1'b0, 3'd0);
      end
    end

    // Scenario 4: simultaneous rise on channels 0 and 3, then ack each in turn.
    sensors_raw = 5'b01001;
    tick(5);
    check_all("s4_edge4", 5'b00000, 5'b00000, 1'b0, 3'd0);
    tick(1);
    check_all("s4_both", 5'b01001, 5'b01001, 1'b1, 3'd0);
    ack = 5'b00001;
    tick(1);
    check_all("s4_ack0", 5'b01001, 5'b01000, 1'b1, 3'd3);
    ack = 5'b01000;
    tick(1);
    ack = '0;
    check_all("s4_ack3", 5'b01001, 5'b00000, 1'b0, 3'd0);
    ack = 5'b10100;
    tick(1);
    ack = '0;
    check_all("s4_ack_idle", 5'b01001, 5'b00000, 1'b0, 3'd0);
    sensors_raw = 5'b00000;
    tick(8);
    check_all("s4_clean", 5'b00000, 5'b00000, 1'b0, 3'd0);

    // Scenario 5: ack held across the rising debounce edge; set wins, then clears.
    sensors_raw = 5'b00010;
    tick(5);
    ack = 5'b00010;
    tick(1);
    check_all("s5_set_wins", 5'b00010, 5'b00010, 1'b1, 3'd1);
    tick(1);
    check_all("s5_cleared", 5'b00010, 5'b00000, 1'b0, 3'd0);
    ack = '0;
    sensors_raw = 5'b00000;
    tick(8);
    check_all("s5_clean", 5'b00000, 5'b00000, 1'b0, 3'd0);

    // Scenario 6: reset mid-request (ch0) and mid-count (ch4, cnt=2).
    sensors_raw = 5'b00001;
    tick(6);
    check_all("s6_req0", 5'b00001, 5'b00001, 1'b1, 3'd0);
    sensors_raw = 5'b10000;
    tick(4);
    check_all("s6_pre_reset", 5'b00001, 5'b00001, 1'b1, 3'd0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_all("s6_reset", 5'b00000, 5'b00000, 1'b0, 3'd0);
    tick(5);
    check_all("s6_edge5", 5'b00000, 5'b00000, 1'b0, 3'd0);
    tick(1);
    check_all("s6_edge6", 5'b10000, 5'b10000, 1'b1, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
